// File: rtl/codificador_seq.sv
// Sequential priority encoder: emits the index of every set request bit, highest first, one per handshake.
// Optional CODIFICADOR_MERGE_EN: a load while busy merges A into the outstanding requests.
module codificador_seq #(
    parameter int W  = 8,
    parameter int SW = $clog2(W)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [W-1:0]  A,
    input  logic          enable,
    input  logic          load,
    output logic [SW-1:0] S,
    output logic          valid,
    input  logic          ready,
    output logic          busy,
    output logic          done,
    output logic          zero
);

    typedef enum logic {IDLE, OUT} state_t;

    state_t       state;
    logic [W-1:0] pending;
    logic [W-1:0] p_clr;
    logic [W-1:0] p_next;
    logic         hs;

    function automatic logic [SW-1:0] pe(input logic [W-1:0] v);
        logic [SW-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < W; i++)
            if (v[i]) idx = SW'(i);
        return idx;
    endfunction

    always_comb begin
        hs    = valid & ready;
        p_clr = pending;
        if (hs) p_clr[S] = 1'b0;
`ifdef CODIFICADOR_MERGE_EN
        p_next = load ? (p_clr | A) : p_clr;
`else
        p_next = p_clr;
`endif
    end

    assign busy = (state == OUT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pending <= '0;
            S       <= '0;
            valid   <= 1'b0;
            done    <= 1'b0;
            zero    <= 1'b0;
        end else begin
            done <= 1'b0;
            zero <= 1'b0;
            if (!enable) begin
                state   <= IDLE;
                pending <= '0;
                S       <= '0;
                valid   <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (load) begin
                            if (|A) begin
                                pending <= A;
                                S       <= pe(A);
                                valid   <= 1'b1;
                                state   <= OUT;
                            end else begin
                                zero <= 1'b1;
                            end
                        end
                    end
                    OUT: begin
                        pending <= p_next;
                        // S only moves on a handshake, so a merge never disturbs a stalled index
                        if (hs) begin
                            if (|p_next) begin
                                S <= pe(p_next);
                            end else begin
                                S     <= '0;
                                valid <= 1'b0;
                                done  <= 1'b1;
                                state <= IDLE;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
